// File: rtl/res_cal_ctrl_if.sv
// Bundles the calibration controller's control, comparator and trim-code signals.
// The controller sits on the slave side; the host and comparator sit on the master side.
interface res_cal_ctrl_if #(
    parameter int N = 6
);
    logic         start;
    logic         track_en;
    logic         comp_hi;
    logic [N-1:0] code;
    logic         code_vld;
    logic         busy;
    logic         done;
    logic         err;

    modport master (
        output start, track_en, comp_hi,
        input  code, code_vld, busy, done, err
    );

    modport slave (
        input  start, track_en, comp_hi,
        output code, code_vld, busy, done, err
    );
endinterface

// File: rtl/res_cal_ctrl.sv
// Trim-resistor calibration sequencer: a SAR search sets the initial code, then an
// optional slow loop tracks drift in +/-1 LSB steps gated by two matching samples.
module res_cal_ctrl #(
    parameter int N            = 6,
    parameter int SETTLE_CYC   = 4,
    parameter int TRACK_PERIOD = 64
) (
    input  logic          clk,
    input  logic          rst,
    res_cal_ctrl_if.slave bus
);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(SETTLE_CYC + 1);
    localparam int PW = $clog2(TRACK_PERIOD + 1);
    localparam logic [N-1:0] MID = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, SAR, TRACK} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  code_q, code_d;
    logic [IW-1:0] idx_q, idx_d, idx_m1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic          hv_q, hv_d;   // history holds one unconsumed sample
    logic          hs_q, hs_d;   // value of that sample
    logic          vld_q, vld_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    assign idx_m1 = idx_q - IW'(1);

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        pcnt_d  = pcnt_q;
        hv_d    = hv_q;
        hs_d    = hs_q;
        vld_d   = vld_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;

        case (state_q)
            SAR: begin
                if (cnt_q == CW'(SETTLE_CYC - 1)) begin
                    if (bus.comp_hi) code_d[idx_q] = 1'b0;
                    if (idx_q != '0) begin
                        code_d[idx_m1] = 1'b1;
                        idx_d          = idx_m1;
                        cnt_d          = '0;
                    end else begin
                        state_d = bus.track_en ? TRACK : IDLE;
                        vld_d   = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pcnt_d  = '0;
                        hv_d    = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            TRACK: begin
                if (!bus.track_en) begin
                    state_d = IDLE;
                end else if (pcnt_q == PW'(TRACK_PERIOD - 1)) begin
                    pcnt_d = '0;
                    if (hv_q && (hs_q == bus.comp_hi)) begin
                        hv_d = 1'b0;
                        // out-of-range steps are dropped and flagged
                        if (bus.comp_hi) begin
                            if (code_q == '0) err_d = 1'b1;
                            else              code_d = code_q - N'(1);
                        end else begin
                            if (code_q == '1) err_d = 1'b1;
                            else              code_d = code_q + N'(1);
                        end
                    end else begin
                        hv_d = 1'b1;
                        hs_d = bus.comp_hi;
                    end
                end else begin
                    pcnt_d = pcnt_q + PW'(1);
                end
            end
            default: ;
        endcase

        // start outranks everything outside an active search, including a tracking sample
        if (state_q != SAR && bus.start) begin
            state_d = SAR;
            code_d  = MID;
            idx_d   = IW'(N - 1);
            cnt_d   = '0;
            hv_d    = 1'b0;
            vld_d   = 1'b0;
            err_d   = 1'b0;
            busy_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            code_q  <= MID;
            idx_q   <= '0;
            cnt_q   <= '0;
            pcnt_q  <= '0;
            hv_q    <= 1'b0;
            hs_q    <= 1'b0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            pcnt_q  <= pcnt_d;
            hv_q    <= hv_d;
            hs_q    <= hs_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.code     = code_q;
    assign bus.code_vld = vld_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_res_cal_ctrl.sv
// Directed bench for res_cal_ctrl (N=4, SETTLE_CYC=2, TRACK_PERIOD=4) with a
// threshold comparator model that can be overridden by a forced value.
module tb_res_cal_ctrl;
    localparam int N  = 4;
    localparam int SC = 2;
    localparam int TP = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   thr = 10;
    bit   frc = 1'b0;
    bit   frc_val = 1'b0;
    int   nvec = 0;
    int   nerr = 0;

    int   tr_code [0:11];
    int   tr_vld  [0:11];
    int   bcnt, dcnt, dedge;

    res_cal_ctrl_if #(.N(N)) bus ();

    res_cal_ctrl #(.N(N), .SETTLE_CYC(SC), .TRACK_PERIOD(TP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.comp_hi = frc ? frc_val : (int'(bus.code) > thr);

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        nvec++;
        if (obs != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // start sampled at edge 0, observe edges 0..11
    task automatic run_sar();
        bcnt  = 0;
        dcnt  = 0;
        dedge = -1;
        bus.start = 1'b1;
        for (int e = 0; e < 12; e++) begin
            tick();
            if (e == 0) bus.start = 1'b0;
            tr_code[e] = int'(bus.code);
            tr_vld[e]  = int'(bus.code_vld);
            if (bus.busy) bcnt++;
            if (bus.done) begin
                dcnt++;
                dedge = e;
            end
        end
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.track_en = 1'b0;
        tick();
        tick();
        chk("rst_code", int'(bus.code), 8);
        chk("rst_vld",  int'(bus.code_vld), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_err",  int'(bus.err), 0);
        rst = 1'b0;
        tick();

        // SAR convergence to 10
        run_sar();
        chk("sar_t0", tr_code[0], 8);
        chk("sar_t1", tr_code[1], 8);
        chk("sar_t2", tr_code[2], 12);
        chk("sar_t4", tr_code[4], 10);
        chk("sar_t6", tr_code[6], 11);
        chk("sar_final", tr_code[8], 10);
        chk("sar_vld_pre", tr_vld[7], 0);
        chk("sar_vld_at_done", tr_vld[8], 1);
        chk("sar_busy_cyc", bcnt, 8);
        chk("sar_done_cnt", dcnt, 1);
        chk("sar_done_edge", dedge, 8);
        chk("sar_hold", tr_code[11], 10);

        // extremes
        frc = 1'b1;
        frc_val = 1'b1;
        run_sar();
        chk("lo_code", tr_code[11], 0);
        chk("lo_done", dcnt, 1);
        chk("lo_err", int'(bus.err), 0);
        frc_val = 1'b0;
        run_sar();
        chk("hi_code", tr_code[11], 15);
        chk("hi_done", dcnt, 1);
        chk("hi_err", int'(bus.err), 0);

        // tracking: calibrate to 10, move threshold to 12; TRACK entered at edge 8
        frc = 1'b0;
        thr = 10;
        bus.track_en = 1'b1;
        run_sar();
        chk("trk_cal", tr_code[11], 10);
        thr = 12;
        for (int e = 12; e <= 24; e++) begin
            tick();
            if (e == 15) chk("trk_e15", int'(bus.code), 10);
            if (e == 16) chk("trk_e16", int'(bus.code), 11);
            if (e == 23) chk("trk_e23", int'(bus.code), 11);
            if (e == 24) chk("trk_e24", int'(bus.code), 12);
        end
        // alternating samples at edges 28,32,36,40,44 never agree twice
        frc = 1'b1;
        for (int e = 25; e <= 46; e++) begin
            frc_val = ((e >> 2) & 1) != 0;
            tick();
        end
        chk("alt_code", int'(bus.code), 12);
        chk("alt_err", int'(bus.err), 0);

        // saturation at 15 in TRACK
        frc_val = 1'b0;
        run_sar();
        chk("sat_cal", tr_code[11], 15);
        for (int e = 12; e <= 24; e++) begin
            tick();
            if (e == 15) chk("sat_err_e15", int'(bus.err), 0);
            if (e == 16) chk("sat_err_e16", int'(bus.err), 1);
        end
        chk("sat_err_sticky", int'(bus.err), 1);
        chk("sat_code", int'(bus.code), 15);

        // restart from TRACK
        frc = 1'b0;
        thr = 10;
        run_sar();
        chk("rs_t0", tr_code[0], 8);
        chk("rs_vld0", tr_vld[0], 0);
        chk("rs_err", int'(bus.err), 0);
        chk("rs_final", tr_code[8], 10);
        chk("rs_busy_cyc", bcnt, 8);
        chk("rs_done_cnt", dcnt, 1);
        chk("rs_done_edge", dedge, 8);

        // leaving TRACK holds code
        bus.track_en = 1'b0;
        tick();
        thr = 0;
        for (int i = 0; i < 20; i++) tick();
        chk("idle_code", int'(bus.code), 10);
        chk("idle_vld", int'(bus.code_vld), 1);

        // reset while bit 2 is settling, with start asserted alongside
        thr = 10;
        bus.start = 1'b1;
        for (int e = 0; e <= 3; e++) begin
            tick();
            if (e == 0) bus.start = 1'b0;
        end
        chk("mid_pre_code", int'(bus.code), 12);
        rst = 1'b1;
        bus.start = 1'b1;
        tick();
        rst = 1'b0;
        bus.start = 1'b0;
        chk("mid_code", int'(bus.code), 8);
        chk("mid_busy", int'(bus.busy), 0);
        chk("mid_vld", int'(bus.code_vld), 0);
        chk("mid_done", int'(bus.done), 0);
        dcnt = 0;
        bcnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done) dcnt++;
            if (bus.busy) bcnt++;
        end
        chk("mid_no_done", dcnt, 0);
        chk("mid_no_busy", bcnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/res_cal_ctrl.md
# res_cal_ctrl

Calibration and tracking controller for a digitally trimmed on-chip resistor (termination or bias resistor bank). It drives an N-bit trim code into the resistor bank and reads a single comparator that compares the replica-resistor voltage against a reference. A successive-approximation (SAR) search produces the initial code. An optional slow tracking loop then follows drift with ±1 LSB steps gated by a two-sample hysteresis. The block is the digital sequencer that sits beside the PWL resistor model in mixed-signal testbenches and in silicon.

## Interface
Parameters:
- N, 6, trim code width; valid range 2..10
- SETTLE_CYC, 4, cycles from code change to comparator sample; must be ≥1
- TRACK_PERIOD, 64, cycles between tracking samples; must be ≥2

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a full SAR calibration; single-cycle pulse or level
- track_en  input  1  enables the tracking loop after calibration completes
- comp_hi  input  1  1 = replica voltage above reference, meaning the code is too large
- code  output  N  trim code to the resistor bank
- code_vld  output  1  code holds a calibrated value
- busy  output  1  SAR search in progress
- done  output  1  one-cycle pulse when the SAR search completes
- err  output  1  sticky flag: tracking requested a step beyond 0 or 2^N−1

## Operation
- Reset values: state IDLE, code = 2^(N−1) (mid-scale), code_vld=0, busy=0, done=0, err=0, all counters 0.
- FSM states: IDLE, SAR, TRACK.
- IDLE:
  - start=1 → SAR. code ← 2^(N−1) (trial MSB), bit index ← N−1, settle counter ← 0, code_vld ← 0, err ← 0, busy ← 1.
- SAR:
  - The settle counter increments each cycle. On the cycle it reaches SETTLE_CYC−1, comp_hi is sampled and the decision is taken at that edge:
    - If comp_hi=1, clear the current trial bit; otherwise keep it.
    - If bit index > 0, set the next lower bit as the new trial in the same edge, decrement the index, and clear the counter.
    - If bit index = 0, go to TRACK when track_en=1, else IDLE. At the same edge set code_vld←1, busy←0, and pulse done for one cycle.
  - start is ignored while in SAR.
- TRACK:
  - A period counter counts TRACK_PERIOD cycles; comp_hi is sampled on the last cycle of each period.
  - A 2-bit history keeps the last two samples. Two consecutive 1s → code−1; two consecutive 0s → code+1. After any step the history clears.
  - Saturation: a step below 0 or above 2^N−1 leaves code unchanged and sets err (sticky).
  - track_en=0 → IDLE at the next edge, code held, code_vld stays 1.
  - start=1 → restart SAR exactly as from IDLE, including the code_vld and err clears. start takes priority over the tracking sample in the same cycle.
- IDLE with code_vld=1 holds code indefinitely.
- rst=1 in any state, including mid-SAR, forces reset values at that edge and overrides start.

## Timing
- start sampled at edge k: trial code visible after edge k.
- Each bit decision lands on edge k+SETTLE_CYC·(b+1), where b = 0..N−1 counts bits from the MSB.
- Final decision and done pulse occur at edge k+N·SETTLE_CYC. done is high for exactly the cycle after that edge, and code_vld rises in the same cycle.
- busy is high for exactly N·SETTLE_CYC cycles.
- code changes only on decision edges or tracking steps. It never glitches between settle samples.
- Tracking cadence: first sample TRACK_PERIOD cycles after entering TRACK. The minimum step spacing is 2·TRACK_PERIOD cycles.
- Combinational input-to-output paths: none. All outputs are registered.

## Test plan
- SAR convergence, N=4, SETTLE_CYC=2, comparator model comp_hi=(code>10), start at edge 0 → trial sequence 8, 12, 10, 11; final code=10; done pulses after edge 8; busy high for 8 cycles.
- Extremes, N=4: comp_hi stuck 1 → code=0; comp_hi stuck 0 → code=15. Both complete with done and err=0.
- Tracking, N=4, TRACK_PERIOD=4, calibrated code=10, then the model threshold moves to 12 → code steps to 11, then 12. Each step requires two consecutive 0 samples, so steps are ≥8 cycles apart. An alternating comp_hi pattern produces no step.
- Saturation: code=15 in TRACK with comp_hi stuck 0 → code stays 15 and err rises after the second sample and stays high. A subsequent start clears err.
- Reset mid-SAR: rst asserted during bit 2 → next cycle code=8, busy=0, code_vld=0, and no done pulse. start in the same cycle as rst is ignored.
- Restart from TRACK: start while tracking → code_vld drops, SAR reruns from mid-scale with the same timing as from IDLE, and done pulses once.
